atax_launcher: RTL and testbench

Invocation sequencer placed directly upstream of the atax HLS component. Queues job descriptors (four 64-bit array base addresses plus a tag), issues one component call at a time on the start/busy call interface with arguments held stable, and accepts the done/stall return interface. Completed calls are reported as responses carrying the tag and the measured call-to-return cycle count.

---
 rtl/atax_launcher.sv | 149 ++++++++++++++
 tb/tb_atax_launcher.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/atax_launcher.sv
// Job queue and call sequencer in front of the atax HLS component: one call in flight,
// arguments held from dispatch until the next dispatch, responses report tag and latency.
module atax_launcher #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [63:0]      job_A,
   input  logic [63:0]      job_x,
   input  logic [63:0]      job_y,
   input  logic [63:0]      job_tmp,
   input  logic [7:0]       job_tag,
   output logic             start,
   input  logic             busy,
   output logic [63:0]      A,
   output logic [63:0]      x,
   output logic [63:0]      y,
   output logic [63:0]      tmp,
   input  logic             done,
   output logic             stall,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [7:0]       resp_tag,
   output logic [CNT_W-1:0] resp_cycles,
   output logic             idle
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] x;
      logic [63:0] y;
      logic [63:0] tmp;
      logic [7:0]  tag;
   } job_t;

   typedef enum logic [1:0] {S_IDLE, S_CALL, S_RUN} state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   job_t             mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   state_t           state_q, state_d;
   job_t             args_q, args_d;
   logic             start_q, start_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             resp_valid_q, resp_valid_d;
   logic [7:0]       resp_tag_q, resp_tag_d;
   logic [CNT_W-1:0] resp_cycles_q, resp_cycles_d;
   logic             idle_q, idle_d;
   logic             push, pop;

   assign job_ready   = (count_q != FULL_CNT);
   assign push        = job_valid && job_ready;
   assign stall       = resp_valid_q && !resp_ready;
   assign start       = start_q;
   assign A           = args_q.a;
   assign x           = args_q.x;
   assign y           = args_q.y;
   assign tmp         = args_q.tmp;
   assign resp_valid  = resp_valid_q;
   assign resp_tag    = resp_tag_q;
   assign resp_cycles = resp_cycles_q;
   assign idle        = idle_q;

   always_comb begin
      state_d       = state_q;
      start_d       = start_q;
      args_d        = args_q;
      cnt_d         = cnt_q;
      resp_valid_d  = resp_valid_q;
      resp_tag_d    = resp_tag_q;
      resp_cycles_d = resp_cycles_q;
      pop           = 1'b0;
      if (resp_valid_q && resp_ready) resp_valid_d = 1'b0;
      unique case (state_q)
         S_IDLE: if (count_q != '0) begin
            pop     = 1'b1;
            args_d  = mem_q[rd_ptr_q];
            start_d = 1'b1;
            state_d = S_CALL;
         end
         S_CALL: if (!busy) begin
            start_d = 1'b0;
            cnt_d   = CNT_W'(1);
            state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = sat_inc(cnt_q);
            // a return only lands when the response register is free or draining
            if (done && !stall) begin
               resp_valid_d  = 1'b1;
               resp_tag_d    = args_q.tag;
               resp_cycles_d = cnt_q;
               state_d       = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      idle_d = (count_d == '0) && (state_d == S_IDLE) && !resp_valid_d;
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= '{a: job_A, x: job_x, y: job_y, tmp: job_tmp, tag: job_tag};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         state_q       <= S_IDLE;
         args_q        <= '0;
         start_q       <= 1'b0;
         cnt_q         <= '0;
         resp_valid_q  <= 1'b0;
         resp_tag_q    <= '0;
         resp_cycles_q <= '0;
         idle_q        <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q       <= count_d;
         state_q       <= state_d;
         args_q        <= args_d;
         start_q       <= start_d;
         cnt_q         <= cnt_d;
         resp_valid_q  <= resp_valid_d;
         resp_tag_q    <= resp_tag_d;
         resp_cycles_q <= resp_cycles_d;
         idle_q        <= idle_d;
      end
   end

endmodule

// File: tb/tb_atax_launcher.sv
// Directed bench for atax_launcher: dispatch timing, back-pressure, queue depth,
// response stall, counter saturation (CNT_W=4 instance) and mid-call reset.
module tb_atax_launcher;

   logic        clock, reset;
   logic        job_valid, job_ready;
   logic [63:0] job_A, job_x, job_y, job_tmp;
   logic [7:0]  job_tag;
   logic        start, busy;
   logic [63:0] A, x, y, tmp;
   logic        done, stall, resp_valid, resp_ready;
   logic [7:0]  resp_tag;
   logic [31:0] resp_cycles;
   logic        idle;

   logic        s_job_valid, s_job_ready, s_start, s_busy, s_done, s_stall;
   logic        s_resp_valid, s_resp_ready, s_idle;
   logic [63:0] s_A, s_x, s_y, s_tmp;
   logic [7:0]  s_resp_tag;
   logic [3:0]  s_resp_cycles;

   int tests = 0;
   int fails = 0;

   atax_launcher #(.DEPTH(4), .CNT_W(32)) dut (
      .clock(clock), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
      .job_A(job_A), .job_x(job_x), .job_y(job_y), .job_tmp(job_tmp), .job_tag(job_tag),
      .start(start), .busy(busy), .A(A), .x(x), .y(y), .tmp(tmp), .done(done),
      .stall(stall), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_tag(resp_tag), .resp_cycles(resp_cycles), .idle(idle));

   atax_launcher #(.DEPTH(4), .CNT_W(4)) u_sat (
      .clock(clock), .reset(reset), .job_valid(s_job_valid), .job_ready(s_job_ready),
      .job_A(64'h11), .job_x(64'h22), .job_y(64'h33), .job_tmp(64'h44), .job_tag(8'h9),
      .start(s_start), .busy(s_busy), .A(s_A), .x(s_x), .y(s_y), .tmp(s_tmp), .done(s_done),
      .stall(s_stall), .resp_valid(s_resp_valid), .resp_ready(s_resp_ready),
      .resp_tag(s_resp_tag), .resp_cycles(s_resp_cycles), .idle(s_idle));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_job(input logic [7:0] t, input logic [63:0] a, input logic [63:0] xx,
                           input logic [63:0] yy, input logic [63:0] tt);
      job_valid = 1'b1; job_tag = t; job_A = a; job_x = xx; job_y = yy; job_tmp = tt;
      step();
      job_valid = 1'b0;
   endtask

   task automatic wait_start();
      for (int i = 0; i < 20 && start !== 1'b1; i++) step();
      tests++;
      if (start !== 1'b1) begin
         fails++;
         $display("FAIL wait_start: start=%b, required 1 within 20 cycles", start);
      end
   endtask

   task automatic complete_job(input logic [7:0] etag, input logic [63:0] ea, input int lat);
      wait_start();
      tests++;
      if (A !== ea) begin fails++; $display("FAIL job_args tag %0d: A=%h, required %h", etag, A, ea); end
      busy = 1'b0;
      step();
      repeat (lat - 1) step();
      done = 1'b1;
      step();
      done = 1'b0;
      tests++;
      if (resp_valid !== 1'b1 || resp_tag !== etag || resp_cycles !== 32'(lat)) begin
         fails++;
         $display("FAIL job_resp: valid=%b tag=%h cycles=%0d, required 1 %h %0d",
                  resp_valid, resp_tag, resp_cycles, etag, lat);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      tests++;
      if (start !== 1'b0 || stall !== 1'b0 || resp_valid !== 1'b0 || job_ready !== 1'b1 ||
          idle !== 1'b1 || A !== 64'h0 || x !== 64'h0 || y !== 64'h0 || tmp !== 64'h0 ||
          resp_tag !== 8'h0 || resp_cycles !== 32'h0) begin
         fails++;
         $display("FAIL reset_state: start=%b stall=%b rv=%b jr=%b idle=%b A=%h tag=%h cyc=%0d",
                  start, stall, resp_valid, job_ready, idle, A, resp_tag, resp_cycles);
      end
      reset = 1'b0;
   endtask

   task automatic test_single_job();
      push_job(8'h5, 64'h1000, 64'h2000, 64'h3000, 64'h4000);
      tests++;
      if (start !== 1'b0 || idle !== 1'b0) begin
         fails++; $display("FAIL single_pop_cycle: start=%b idle=%b, required 0 0", start, idle);
      end
      step();
      tests++;
      if (start !== 1'b1 || A !== 64'h1000 || x !== 64'h2000 || y !== 64'h3000 || tmp !== 64'h4000) begin
         fails++;
         $display("FAIL single_call: start=%b A=%h x=%h y=%h tmp=%h, required 1 1000 2000 3000 4000",
                  start, A, x, y, tmp);
      end
      step();
      tests++;
      if (start !== 1'b0 || A !== 64'h1000) begin
         fails++; $display("FAIL single_start_pulse: start=%b A=%h, required 0 1000", start, A);
      end
      repeat (9) step();
      done = 1'b1;
      step();
      done = 1'b0;
      tests++;
      if (resp_valid !== 1'b1 || resp_tag !== 8'h5 || resp_cycles !== 32'd10 || tmp !== 64'h4000) begin
         fails++;
         $display("FAIL single_resp: valid=%b tag=%h cycles=%0d tmp=%h, required 1 05 10 4000",
                  resp_valid, resp_tag, resp_cycles, tmp);
      end
      step();
      tests++;
      if (resp_valid !== 1'b0 || idle !== 1'b1) begin
         fails++; $display("FAIL single_drain: valid=%b idle=%b, required 0 1", resp_valid, idle);
      end
   endtask

   task automatic test_busy();
      busy = 1'b1;
      push_job(8'h21, 64'hAAAA, 64'h1, 64'h2, 64'h3);
      wait_start();
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (start !== 1'b1 || A !== 64'hAAAA || tmp !== 64'h3) begin
            fails++; $display("FAIL busy_hold[%0d]: start=%b A=%h, required 1 aaaa", i, start, A);
         end
         if (i == 3) busy = 1'b0;
         step();
      end
      tests++;
      if (start !== 1'b0) begin fails++; $display("FAIL busy_release: start=%b, required 0", start); end
      done = 1'b1;
      step();
      done = 1'b0;
      tests++;
      if (resp_valid !== 1'b1 || resp_tag !== 8'h21 || resp_cycles !== 32'd1) begin
         fails++;
         $display("FAIL busy_resp: valid=%b tag=%h cycles=%0d, required 1 21 1", resp_valid, resp_tag, resp_cycles);
      end
      step();
   endtask

   task automatic test_queue_full();
      busy = 1'b1;
      for (int t = 1; t <= 5; t++) begin
         tests++;
         if (job_ready !== 1'b1) begin fails++; $display("FAIL q_ready[%0d]: job_ready=%b, required 1", t, job_ready); end
         push_job(8'(t), 64'h10000 * t, 64'h0, 64'h0, 64'h0);
      end
      tests++;
      if (job_ready !== 1'b0) begin fails++; $display("FAIL q_full: job_ready=%b, required 0", job_ready); end
      push_job(8'h6, 64'h60000, 64'h0, 64'h0, 64'h0);
      tests++;
      if (job_ready !== 1'b0) begin fails++; $display("FAIL q_refuse: job_ready=%b, required 0", job_ready); end
      for (int t = 1; t <= 5; t++) complete_job(8'(t), 64'h10000 * t, 2);
      step();
      step();
      tests++;
      if (idle !== 1'b1 || start !== 1'b0) begin
         fails++; $display("FAIL q_sixth_dropped: idle=%b start=%b, required 1 0", idle, start);
      end
   endtask

   task automatic test_resp_backpressure();
      busy = 1'b0;
      resp_ready = 1'b0;
      push_job(8'h1, 64'hA000, 64'h0, 64'h0, 64'h0);
      push_job(8'h2, 64'hB000, 64'h0, 64'h0, 64'h0);
      complete_job(8'h1, 64'hA000, 4);
      wait_start();
      step();
      done = 1'b1;
      step();
      tests++;
      if (stall !== 1'b1 || resp_tag !== 8'h1 || resp_valid !== 1'b1) begin
         fails++; $display("FAIL bp_stall1: stall=%b tag=%h valid=%b, required 1 01 1", stall, resp_tag, resp_valid);
      end
      step();
      tests++;
      if (stall !== 1'b1 || resp_tag !== 8'h1) begin
         fails++; $display("FAIL bp_stall2: stall=%b tag=%h, required 1 01", stall, resp_tag);
      end
      resp_ready = 1'b1;
      #1;
      tests++;
      if (stall !== 1'b0) begin fails++; $display("FAIL bp_unstall: stall=%b, required 0", stall); end
      step();
      done = 1'b0;
      tests++;
      if (resp_valid !== 1'b1 || resp_tag !== 8'h2 || resp_cycles !== 32'd3) begin
         fails++;
         $display("FAIL bp_reload: valid=%b tag=%h cycles=%0d, required 1 02 3", resp_valid, resp_tag, resp_cycles);
      end
      step();
      tests++;
      if (resp_valid !== 1'b0 || idle !== 1'b1) begin
         fails++; $display("FAIL bp_drain: valid=%b idle=%b, required 0 1", resp_valid, idle);
      end
   endtask

   task automatic test_saturation();
      s_job_valid = 1'b1;
      step();
      s_job_valid = 1'b0;
      for (int i = 0; i < 20 && s_start !== 1'b1; i++) step();
      tests++;
      if (s_start !== 1'b1) begin fails++; $display("FAIL sat_start: start=%b, required 1", s_start); end
      step();
      repeat (19) step();
      s_done = 1'b1;
      step();
      s_done = 1'b0;
      tests++;
      if (s_resp_valid !== 1'b1 || s_resp_cycles !== 4'hF || s_resp_tag !== 8'h9) begin
         fails++;
         $display("FAIL sat_cycles: valid=%b cycles=%0d tag=%h, required 1 15 09", s_resp_valid, s_resp_cycles, s_resp_tag);
      end
      step();
   endtask

   task automatic test_reset_mid_call();
      busy = 1'b0;
      resp_ready = 1'b1;
      push_job(8'h7, 64'hC000, 64'h0, 64'h0, 64'h0);
      push_job(8'h8, 64'hD000, 64'h0, 64'h0, 64'h0);
      wait_start();
      step();
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      tests++;
      if (start !== 1'b0 || resp_valid !== 1'b0 || idle !== 1'b1 || A !== 64'h0 || job_ready !== 1'b1) begin
         fails++;
         $display("FAIL rst_run: start=%b valid=%b idle=%b A=%h jr=%b, required 0 0 1 0 1",
                  start, resp_valid, idle, A, job_ready);
      end
      done = 1'b1;
      step();
      step();
      done = 1'b0;
      step();
      tests++;
      if (resp_valid !== 1'b0 || idle !== 1'b1 || start !== 1'b0) begin
         fails++;
         $display("FAIL rst_done_ignored: valid=%b idle=%b start=%b, required 0 1 0", resp_valid, idle, start);
      end
   endtask

   initial begin
      reset = 1'b1; job_valid = 1'b0; job_A = '0; job_x = '0; job_y = '0; job_tmp = '0;
      job_tag = '0; busy = 1'b0; done = 1'b0; resp_ready = 1'b1;
      s_job_valid = 1'b0; s_busy = 1'b0; s_done = 1'b0; s_resp_ready = 1'b1;
      test_reset();
      test_single_job();
      test_busy();
      test_queue_full();
      test_resp_backpressure();
      test_saturation();
      test_reset_mid_call();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
